// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter for one single-port synchronous memory, with bounded burst hold and routed rvalid.
// Optional build macro MEM_ARB_PORT0_PRIO_EN: port 0 preempts without disturbing the round-robin state.
module mem_arbiter_rr #(
  parameter  int NPORTS     = 3,
  parameter  int PORTW      = 32,
  parameter  int ADDRWIDTH  = 7,
  parameter  int MAX_HOLD   = 2,
  parameter  int RD_LATENCY = 1,
  localparam int IDXW       = $clog2(NPORTS)
) (
  input  logic                        clk,
  input  logic                        rstx,
  input  logic [NPORTS-1:0]           en_x_in,
  input  logic [NPORTS-1:0]           wr_x_in,
  input  logic [NPORTS*ADDRWIDTH-1:0] addr_in,
  input  logic [NPORTS*PORTW-1:0]     d_in,
  input  logic [NPORTS*PORTW-1:0]     bit_wr_x_in,
  output logic [NPORTS-1:0]           busy,
  output logic [NPORTS-1:0]           rvalid,
  output logic                        mem_en_x,
  output logic                        mem_wr_x,
  output logic [ADDRWIDTH-1:0]        mem_addr,
  output logic [PORTW-1:0]            mem_d,
  output logic [PORTW-1:0]            mem_bit_wr_x,
  output logic [IDXW-1:0]             grant_idx
);

  localparam int HOLDW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [IDXW-1:0]   r_owner;
  logic [HOLDW-1:0]  r_hold;
  logic              r_owned;  // owner has been granted since reset; before that there is no burst to continue
  logic [NPORTS-1:0] r_rv_pipe [RD_LATENCY];

  logic [NPORTS-1:0] w_req;
  logic              w_any;
  logic              w_found;
  logic              w_preempt;
  logic [IDXW-1:0]   w_grant;
  logic [NPORTS-1:0] w_gnt_oh;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_req     = ~en_x_in;
    w_any     = |w_req;
    w_found   = 1'b0;
    w_preempt = 1'b0;
    w_grant   = '0;
    if (r_owned && w_req[r_owner] && (int'(r_hold) < MAX_HOLD - 1)) begin
      w_grant = r_owner;
      w_found = 1'b1;
    end
    // Scan starts just past the owner and wraps back onto it, so a sole requester always wins.
    for (int k = 1; k <= NPORTS; k++) begin
      if (!w_found && w_req[(int'(r_owner) + k) % NPORTS]) begin
        w_grant = IDXW'((int'(r_owner) + k) % NPORTS);
        w_found = 1'b1;
      end
    end
`ifdef MEM_ARB_PORT0_PRIO_EN
    if (w_req[0]) begin
      w_grant   = '0;
      w_preempt = 1'b1;
    end
`endif
    w_gnt_oh = w_any ? (NPORTS'(1) << w_grant) : '0;
  end

  always_comb begin
    mem_en_x     = 1'b1;
    mem_wr_x     = 1'b1;
    mem_addr     = '0;
    mem_d        = '0;
    mem_bit_wr_x = '1;
    grant_idx    = '0;
    busy         = '1;
    rvalid       = '0;
    if (rstx) begin
      busy   = w_req & ~w_gnt_oh;
      rvalid = r_rv_pipe[RD_LATENCY-1];
      if (w_any) begin
        mem_en_x     = 1'b0;
        mem_wr_x     = wr_x_in[w_grant];
        mem_addr     = addr_in[int'(w_grant)*ADDRWIDTH +: ADDRWIDTH];
        mem_d        = d_in[int'(w_grant)*PORTW +: PORTW];
        mem_bit_wr_x = bit_wr_x_in[int'(w_grant)*PORTW +: PORTW];
        grant_idx    = w_grant;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstx) begin
      r_owner <= IDXW'(NPORTS - 1);
      r_hold  <= '0;
      r_owned <= 1'b0;
      // NOTE: the rvalid pipe is reset explicitly so reads in flight at reset never surface afterwards.
      for (int s = 0; s < RD_LATENCY; s++) r_rv_pipe[s] <= '0;
    end else begin
      if (w_any && !w_preempt) begin
        if (r_owned && (w_grant == r_owner)) begin
          if (int'(r_hold) < MAX_HOLD - 1) r_hold <= r_hold + 1'b1;
        end else begin
          r_owner <= w_grant;
          r_hold  <= '0;
        end
        r_owned <= 1'b1;
      end else if (!w_any) begin
        r_hold <= '0;
      end
      r_rv_pipe[0] <= (w_any && wr_x_in[w_grant]) ? w_gnt_oh : '0;
      for (int s = 1; s < RD_LATENCY; s++) r_rv_pipe[s] <= r_rv_pipe[s-1];
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: instance a (MAX_HOLD=2, RD_LATENCY=1) and b (MAX_HOLD=1, RD_LATENCY=2) share stimulus.
// Grants come from a hand-derived vector table; rvalid is checked against a per-instance scoreboard queue.
module tb_mem_arbiter_rr;

  logic        clk = 1'b0;
  logic        rstx;
  logic [2:0]  en_x_in;
  logic [2:0]  wr_x_in;
  logic [20:0] addr_in;
  logic [95:0] d_in;
  logic [95:0] bit_wr_x_in;

  logic [2:0]  busy_a, rvalid_a, busy_b, rvalid_b;
  logic        mem_en_x_a, mem_wr_x_a, mem_en_x_b, mem_wr_x_b;
  logic [6:0]  mem_addr_a, mem_addr_b;
  logic [31:0] mem_d_a, mem_bit_wr_x_a, mem_d_b, mem_bit_wr_x_b;
  logic [1:0]  grant_idx_a, grant_idx_b;

  logic [6:0]  addr_t [3];
  logic [31:0] data_t [3];
  logic [31:0] mask_t [3];

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NPORTS(3), .PORTW(32), .ADDRWIDTH(7), .MAX_HOLD(2), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .rstx(rstx), .en_x_in(en_x_in), .wr_x_in(wr_x_in), .addr_in(addr_in),
    .d_in(d_in), .bit_wr_x_in(bit_wr_x_in), .busy(busy_a), .rvalid(rvalid_a),
    .mem_en_x(mem_en_x_a), .mem_wr_x(mem_wr_x_a), .mem_addr(mem_addr_a), .mem_d(mem_d_a),
    .mem_bit_wr_x(mem_bit_wr_x_a), .grant_idx(grant_idx_a));

  mem_arbiter_rr #(.NPORTS(3), .PORTW(32), .ADDRWIDTH(7), .MAX_HOLD(1), .RD_LATENCY(2)) u_dut_b (
    .clk(clk), .rstx(rstx), .en_x_in(en_x_in), .wr_x_in(wr_x_in), .addr_in(addr_in),
    .d_in(d_in), .bit_wr_x_in(bit_wr_x_in), .busy(busy_b), .rvalid(rvalid_b),
    .mem_en_x(mem_en_x_b), .mem_wr_x(mem_wr_x_b), .mem_addr(mem_addr_b), .mem_d(mem_d_b),
    .mem_bit_wr_x(mem_bit_wr_x_b), .grant_idx(grant_idx_b));

  typedef struct {
    logic       rstx;
    logic [2:0] en_x;
    logic [2:0] wr_x;
    logic [1:0] ga;
    logic [2:0] ba;
    logic [1:0] gb;
    logic [2:0] bb;
    string      name;
  } vec_t;

  typedef struct {
    int         due;
    logic [2:0] vec;
  } rv_t;

  vec_t tbl[$];
  rv_t  qa[$];
  rv_t  qb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic add(input logic r, input logic [2:0] en, input logic [2:0] wr, input logic [1:0] ga,
                     input logic [2:0] ba, input logic [1:0] gb, input logic [2:0] bb, input string name);
    vec_t v;
    v.rstx = r; v.en_x = en; v.wr_x = wr; v.ga = ga; v.ba = ba; v.gb = gb; v.bb = bb; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic       granted;
    logic [2:0] exp_rv_a;
    logic [2:0] exp_rv_b;
    @(negedge clk);
    rstx    = v.rstx;
    en_x_in = v.en_x;
    wr_x_in = v.wr_x;
    #1;
    if (!v.rstx) begin
      qa.delete();
      qb.delete();
    end
    exp_rv_a = '0;
    exp_rv_b = '0;
    if (qa.size() > 0 && qa[0].due == cyc) exp_rv_a = qa.pop_front().vec;
    if (qb.size() > 0 && qb[0].due == cyc) exp_rv_b = qb.pop_front().vec;
    granted = v.rstx && (v.en_x != 3'b111);

    check({v.name, " grant_a"},  32'(grant_idx_a), 32'(v.ga));
    check({v.name, " busy_a"},   32'(busy_a), 32'(v.ba));
    check({v.name, " en_x_a"},   32'(mem_en_x_a), 32'(!granted));
    check({v.name, " wr_x_a"},   32'(mem_wr_x_a), granted ? 32'(v.wr_x[v.ga]) : 32'd1);
    check({v.name, " addr_a"},   32'(mem_addr_a), granted ? 32'(addr_t[v.ga]) : 32'd0);
    check({v.name, " d_a"},      mem_d_a, granted ? data_t[v.ga] : 32'd0);
    check({v.name, " mask_a"},   mem_bit_wr_x_a, granted ? mask_t[v.ga] : 32'hFFFF_FFFF);
    check({v.name, " rvalid_a"}, 32'(rvalid_a), 32'(exp_rv_a));

    check({v.name, " grant_b"},  32'(grant_idx_b), 32'(v.gb));
    check({v.name, " busy_b"},   32'(busy_b), 32'(v.bb));
    check({v.name, " en_x_b"},   32'(mem_en_x_b), 32'(!granted));
    check({v.name, " addr_b"},   32'(mem_addr_b), granted ? 32'(addr_t[v.gb]) : 32'd0);
    check({v.name, " rvalid_b"}, 32'(rvalid_b), 32'(exp_rv_b));

    if (granted && v.wr_x[v.ga]) qa.push_back('{due: cyc + 1, vec: 3'b001 << v.ga});
    if (granted && v.wr_x[v.gb]) qb.push_back('{due: cyc + 2, vec: 3'b001 << v.gb});
    cyc++;
  endtask

  initial begin
    addr_t[0] = 7'h05;        addr_t[1] = 7'h0A;        addr_t[2] = 7'h15;
    data_t[0] = 32'h0000_1111; data_t[1] = 32'hDEAD_BEEF; data_t[2] = 32'hCAFE_0002;
    mask_t[0] = 32'hFFFF_0000; mask_t[1] = 32'h0000_0000; mask_t[2] = 32'h0000_FFFF;
    addr_in     = {addr_t[2], addr_t[1], addr_t[0]};
    d_in        = {data_t[2], data_t[1], data_t[0]};
    bit_wr_x_in = {mask_t[2], mask_t[1], mask_t[0]};
    rstx    = 1'b0;
    en_x_in = 3'b111;
    wr_x_in = 3'b111;

    //  rstx en_x    wr_x    ga ba      gb bb
    add(0, 3'b000, 3'b111, 0, 3'b111, 0, 3'b111, "reset0");
    add(0, 3'b000, 3'b111, 0, 3'b111, 0, 3'b111, "reset1");
    add(1, 3'b000, 3'b111, 0, 3'b110, 0, 3'b110, "all_c0");
    add(1, 3'b000, 3'b111, 0, 3'b110, 1, 3'b101, "all_c1");
    add(1, 3'b000, 3'b111, 1, 3'b101, 2, 3'b011, "all_c2");
    add(1, 3'b000, 3'b111, 1, 3'b101, 0, 3'b110, "all_c3");
    add(1, 3'b000, 3'b111, 2, 3'b011, 1, 3'b101, "all_c4");
    add(1, 3'b000, 3'b111, 2, 3'b011, 2, 3'b011, "all_c5");
    add(1, 3'b000, 3'b111, 0, 3'b110, 0, 3'b110, "all_c6");
    add(1, 3'b001, 3'b111, 1, 3'b100, 1, 3'b100, "p12_c0");
    add(1, 3'b001, 3'b111, 1, 3'b100, 2, 3'b010, "p12_c1");
    add(1, 3'b001, 3'b111, 2, 3'b010, 1, 3'b100, "p12_c2");
    add(1, 3'b001, 3'b111, 2, 3'b010, 2, 3'b010, "p12_c3");
    add(1, 3'b101, 3'b111, 1, 3'b000, 1, 3'b000, "p1_solo0");
    add(1, 3'b101, 3'b111, 1, 3'b000, 1, 3'b000, "p1_solo1");
    add(1, 3'b101, 3'b101, 1, 3'b000, 1, 3'b000, "p1_write0");
    add(1, 3'b101, 3'b101, 1, 3'b000, 1, 3'b000, "p1_write1");
    add(1, 3'b111, 3'b111, 0, 3'b000, 0, 3'b000, "idle0");
    add(1, 3'b011, 3'b111, 2, 3'b000, 2, 3'b000, "p2_read");
    add(1, 3'b111, 3'b111, 0, 3'b000, 0, 3'b000, "idle1");
    add(1, 3'b111, 3'b111, 0, 3'b000, 0, 3'b000, "idle2");
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Port 0 arrives while port 1 has just started a burst.
    apply('{rstx: 1, en_x: 3'b101, wr_x: 3'b111, ga: 1, ba: 3'b000, gb: 1, bb: 3'b000, name: "burst_p1"});
`ifdef MEM_ARB_PORT0_PRIO_EN
    apply('{rstx: 1, en_x: 3'b100, wr_x: 3'b111, ga: 0, ba: 3'b010, gb: 0, bb: 3'b010, name: "p0_preempt"});
    apply('{rstx: 1, en_x: 3'b101, wr_x: 3'b111, ga: 1, ba: 3'b000, gb: 1, bb: 3'b000, name: "p1_resume"});
`else
    apply('{rstx: 1, en_x: 3'b100, wr_x: 3'b111, ga: 1, ba: 3'b001, gb: 0, bb: 3'b010, name: "p0_wait"});
    apply('{rstx: 1, en_x: 3'b100, wr_x: 3'b111, ga: 0, ba: 3'b010, gb: 1, bb: 3'b001, name: "p0_after_hold"});
`endif
    // A read goes out, then reset lands before either instance returns it.
    apply('{rstx: 1, en_x: 3'b101, wr_x: 3'b111, ga: 1, ba: 3'b000, gb: 1, bb: 3'b000, name: "read_pending"});
    apply('{rstx: 0, en_x: 3'b101, wr_x: 3'b111, ga: 0, ba: 3'b111, gb: 0, bb: 3'b111, name: "mid_reset"});
    apply('{rstx: 1, en_x: 3'b111, wr_x: 3'b111, ga: 0, ba: 3'b000, gb: 0, bb: 3'b000, name: "post_reset0"});
    apply('{rstx: 1, en_x: 3'b111, wr_x: 3'b111, ga: 0, ba: 3'b000, gb: 0, bb: 3'b000, name: "post_reset1"});
    apply('{rstx: 1, en_x: 3'b000, wr_x: 3'b111, ga: 0, ba: 3'b110, gb: 0, bb: 3'b110, name: "restart"});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
